// File: rtl/mul_request_arbiter.sv
// Round-robin arbiter that lets two requesters share one 8x8 multiplier handshake.
// Define MUL_ARB_TIMEOUT_EN to build the WAIT-state abort counter (limit TIMEOUT_CYCLES).
module mul_request_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [15:0] req_ba0,
   input  logic [15:0] req_ba1,
   output logic [1:0]  ack,
   output logic [15:0] prod,
   output logic        err,
   output logic        busy,
   output logic        grant_id,
   output logic        mul_start,
   output logic [15:0] mul_ip_BA,
   input  logic [15:0] mul_op_prod,
   input  logic        mul_ready
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RELEASE
   } state_t;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must lie within 1..255");
   end

   state_t      state_q;
   logic [1:0]  ack_q;
   logic [15:0] prod_q;
   logic        busy_q;
   logic        grant_id_q;
   logic        mul_start_q;
   logic [15:0] mul_ip_ba_q;
   logic        last_q;
   logic        grant_d;

`ifdef MUL_ARB_TIMEOUT_EN
   logic [7:0]  tmo_q;
   logic        err_q;
   logic        tmo_hit;

   // The counter reaches the limit on the edge where it would step to TIMEOUT_CYCLES.
   assign tmo_hit = (tmo_q == 8'(TIMEOUT_CYCLES - 1));
   assign err     = err_q;
`else
   assign err     = 1'b0;
`endif

   // NOTE: give every combinational output a default first so no latch is inferred.
   always_comb begin
      grant_d = req[1];
      if (req == 2'b11) grant_d = ~last_q;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         ack_q       <= 2'b00;
         prod_q      <= 16'h0000;
         busy_q      <= 1'b0;
         grant_id_q  <= 1'b0;
         mul_start_q <= 1'b0;
         mul_ip_ba_q <= 16'h0000;
         last_q      <= 1'b1;
`ifdef MUL_ARB_TIMEOUT_EN
         tmo_q       <= 8'd0;
         err_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req != 2'b00) begin
                  grant_id_q  <= grant_d;
                  mul_ip_ba_q <= grant_d ? req_ba1 : req_ba0;
                  mul_start_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= ST_WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
                  tmo_q       <= 8'd0;
`endif
               end
            end
            ST_WAIT: begin
               if (mul_ready) begin
                  prod_q      <= mul_op_prod;
                  ack_q       <= grant_id_q ? 2'b10 : 2'b01;
                  mul_start_q <= 1'b0;
                  last_q      <= grant_id_q;
                  state_q     <= ST_RELEASE;
`ifdef MUL_ARB_TIMEOUT_EN
               end else if (tmo_hit) begin
                  prod_q      <= 16'h0000;
                  ack_q       <= grant_id_q ? 2'b10 : 2'b01;
                  err_q       <= 1'b1;
                  mul_start_q <= 1'b0;
                  last_q      <= grant_id_q;
                  state_q     <= ST_RELEASE;
               end else begin
                  tmo_q       <= tmo_q + 8'd1;
`endif
               end
            end
            ST_RELEASE: begin
               ack_q <= 2'b00;
`ifdef MUL_ARB_TIMEOUT_EN
               err_q <= 1'b0;
`endif
               // Holding here until the multiplier is idle keeps a stale req from re-winning.
               if (!mul_ready) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ack       = ack_q;
   assign prod      = prod_q;
   assign busy      = busy_q;
   assign grant_id  = grant_id_q;
   assign mul_start = mul_start_q;
   assign mul_ip_BA = mul_ip_ba_q;

endmodule

// File: tb/tb_mul_request_arbiter.sv
// Scoreboard bench for mul_request_arbiter: a behavioural multiplier, two requesters,
// a spec-level reference that queues expected grants/results, and a decoupled monitor.
module tb_mul_request_arbiter;

   localparam int TO          = 10;
   localparam int ACK_BUDGET  = 3000;
   localparam int PH_IDLE     = 0;
   localparam int PH_WAIT     = 1;
   localparam int PH_RELEASE  = 2;

   typedef struct {
      int          cyc;
      logic        id;
      logic [15:0] ba;
   } grant_t;

   typedef struct {
      int          cyc;
      logic        id;
      logic [15:0] prod;
      logic        err;
   } done_t;

   typedef struct {
      logic        id;
      logic [15:0] prod;
      logic        err;
   } ack_t;

   logic        clk;
   logic        reset;
   logic        req0, req1;
   logic [15:0] ba0, ba1;
   logic [1:0]  ack;
   logic [15:0] prod;
   logic        err;
   logic        busy;
   logic        grant_id;
   logic        mul_start;
   logic [15:0] mul_ip_BA;
   logic [15:0] mul_op_prod;
   logic        mul_ready;

   int          n_checks;
   int          n_err;
   int          cyc;
   int          mul_en;
   int          mdl_lat;
   int          mdl_hold;

   grant_t      exp_grant[$];
   done_t       exp_done[$];
   ack_t        ack_log[$];

   int          ref_phase;
   logic        ref_last;
   logic        ref_id;
   logic [15:0] ref_ba;
   int          ref_wait_cnt;

   mul_request_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        ({req1, req0}),
      .req_ba0    (ba0),
      .req_ba1    (ba1),
      .ack        (ack),
      .prod       (prod),
      .err        (err),
      .busy       (busy),
      .grant_id   (grant_id),
      .mul_start  (mul_start),
      .mul_ip_BA  (mul_ip_BA),
      .mul_op_prod(mul_op_prod),
      .mul_ready  (mul_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d, required $finish earlier", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural multiplier: answers each start after a latency, then holds ready a while.
   initial begin
      int lat;
      int hold;
      mul_ready   = 1'b0;
      mul_op_prod = 16'h0000;
      forever begin
         @(posedge clk); #1;
         if (mul_en != 0 && reset && mul_start && !mul_ready) begin
            lat  = (mdl_lat  < 0) ? int'($urandom_range(4, 0)) : mdl_lat;
            hold = (mdl_hold < 0) ? int'($urandom_range(4, 1)) : mdl_hold;
            repeat (lat) begin @(posedge clk); #1; end
            mul_op_prod = 16'(mul_ip_BA[15:8]) * 16'(mul_ip_BA[7:0]);
            mul_ready   = 1'b1;
            repeat (hold) begin @(posedge clk); #1; end
            mul_ready   = 1'b0;
         end
      end
   end

   // Reference: who should win each grant and when each result is due, from the arbitration rules.
   always @(posedge clk) begin
      logic [15:0] p;
      cyc++;
      if (!reset) begin
         ref_phase = PH_IDLE;
         ref_last  = 1'b1;
         ref_id    = 1'b0;
         exp_grant.delete();
         exp_done.delete();
      end else begin
         case (ref_phase)
            PH_IDLE: if (req0 || req1) begin
               ref_id       = (req0 && req1) ? !ref_last : req1;
               ref_ba       = ref_id ? ba1 : ba0;
               ref_wait_cnt = 0;
               exp_grant.push_back('{cyc, ref_id, ref_ba});
               ref_phase    = PH_WAIT;
            end
            PH_WAIT: begin
               ref_wait_cnt++;
               p = 16'(ref_ba[15:8]) * 16'(ref_ba[7:0]);
               if (mul_ready) begin
                  exp_done.push_back('{cyc, ref_id, p, 1'b0});
                  ref_last  = ref_id;
                  ref_phase = PH_RELEASE;
               end
`ifdef MUL_ARB_TIMEOUT_EN
               else if (ref_wait_cnt == TO) begin
                  exp_done.push_back('{cyc, ref_id, 16'h0000, 1'b1});
                  ref_last  = ref_id;
                  ref_phase = PH_RELEASE;
               end
`endif
            end
            default: if (!mul_ready) ref_phase = PH_IDLE;
         endcase
      end
   end

   // Monitor: pops the scoreboard whenever the DUT starts the multiplier or acknowledges.
   always @(posedge clk) begin
      logic        start_prev;
      logic [15:0] hold_prod;
      logic [15:0] hold_ba;
      grant_t      g;
      done_t       d;
      #1;
      if (!reset) begin
         hold_prod = 16'h0000;
         hold_ba   = 16'h0000;
      end else begin
         if (mul_start && !start_prev) begin
            if (exp_grant.size() == 0) check("spurious_grant_queue_size", 32'(exp_grant.size()), 1);
            else begin
               g = exp_grant.pop_front();
               check("grant_cycle", cyc, g.cyc + 0);
               check("grant_winner", 32'(grant_id), 32'(g.id));
               check("grant_operands", 32'(mul_ip_BA), 32'(g.ba));
               hold_ba = g.ba;
            end
         end
         if (ack != 2'b00) begin
            if (exp_done.size() == 0) check("spurious_ack_queue_size", 32'(exp_done.size()), 1);
            else begin
               d = exp_done.pop_front();
               check("ack_cycle", cyc, d.cyc);
               check("ack_bits", 32'(ack), d.id ? 32'h2 : 32'h1);
               check("ack_err", 32'(err), 32'(d.err));
               check("ack_mul_start", 32'(mul_start), 0);
               hold_prod = d.prod;
               ack_log.push_back('{d.id, prod, err});
            end
         end else begin
            check("err_without_ack", 32'(err), 0);
         end
         check("prod", 32'(prod), 32'(hold_prod));
         check("mul_ip_BA_held", 32'(mul_ip_BA), 32'(hold_ba));
         check("busy", 32'(busy), 32'(ref_phase != PH_IDLE));
         check("mul_start_level", 32'(mul_start), 32'(ref_phase == PH_WAIT));
         check("grant_id_level", 32'(grant_id), 32'(ref_id));
      end
      start_prev = mul_start;
   end

   task automatic do_req(input int i, input logic [15:0] ba);
      int n;
      if (i == 0) begin ba0 = ba; req0 = 1'b1; end
      else        begin ba1 = ba; req1 = 1'b1; end
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (ack[i] !== 1'b1 && n < ACK_BUDGET);
      check($sformatf("ack_arrived_req%0d", i), 32'(ack[i]), 1);
      @(posedge clk); #1;
      if (i == 0) req0 = 1'b0;
      else        req1 = 1'b0;
   endtask

   task automatic req_stream(input int i, input int count, input int max_gap);
      int gap;
      repeat (count) begin
         gap = int'($urandom_range(max_gap, 0));
         repeat (gap) begin @(posedge clk); #1; end
         do_req(i, 16'($urandom));
      end
   endtask

   initial begin
      int n;
      n_checks = 0;
      n_err    = 0;
      cyc      = 0;
      reset    = 1'b0;
      req0     = 1'b0;
      req1     = 1'b0;
      ba0      = 16'h0000;
      ba1      = 16'h0000;
      mul_en   = 1;
      mdl_lat  = -1;
      mdl_hold = -1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", 32'(ack), 0);
      check("rst_prod", 32'(prod), 0);
      check("rst_err", 32'(err), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_grant_id", 32'(grant_id), 0);
      check("rst_mul_start", 32'(mul_start), 0);
      check("rst_mul_ip_BA", 32'(mul_ip_BA), 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Single request with a fixed 5-cycle multiplier.
      mdl_lat  = 5;
      mdl_hold = 1;
      ack_log.delete();
      do_req(0, 16'h0C0A);
      check("single_count", 32'(ack_log.size()), 1);
      if (ack_log.size() >= 1) begin
         check("single_id", 32'(ack_log[0].id), 0);
         check("single_prod", 32'(ack_log[0].prod), 32'h0078);
      end
      check("single_ba_held", 32'(mul_ip_BA), 32'h0C0A);

      // Tie straight after reset: requester 0 must win first.
      reset = 1'b0;
      @(posedge clk); #1;
      reset    = 1'b1;
      mdl_lat  = -1;
      mdl_hold = -1;
      ack_log.delete();
      fork
         do_req(0, 16'h0203);
         do_req(1, 16'hFFFF);
      join
      check("tie_count", 32'(ack_log.size()), 2);
      if (ack_log.size() >= 2) begin
         check("tie_first_id", 32'(ack_log[0].id), 0);
         check("tie_first_prod", 32'(ack_log[0].prod), 32'h0006);
         check("tie_second_id", 32'(ack_log[1].id), 1);
         check("tie_second_prod", 32'(ack_log[1].prod), 32'hFE01);
      end

      // Slow mul_ready fall with requester 1 pending.
      mdl_hold = 5;
      fork
         do_req(0, 16'($urandom));
         begin @(posedge clk); #1; do_req(1, 16'($urandom)); end
      join
      mdl_hold = -1;

      // Randomised contention; requester 0 re-requests with no gap at times.
      fork
         req_stream(0, 40, 2);
         req_stream(1, 40, 3);
      join

      // Reset in the middle of WAIT.
      repeat (6) @(posedge clk);
      #1;
      mul_en = 0;
      ba0    = 16'h1234;
      req0   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("midwait_busy", 32'(busy), 1);
      check("midwait_mul_start", 32'(mul_start), 1);
      #3;
      reset = 1'b0;
      #1;
      check("async_mul_start", 32'(mul_start), 0);
      check("async_busy", 32'(busy), 0);
      check("async_ack", 32'(ack), 0);
      req0 = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check("reset_no_ack", 32'(ack), 0);
      end
      reset  = 1'b1;
      mul_en = 1;
      @(posedge clk); #1;
      check("post_reset_idle", 32'(busy), 0);

`ifdef MUL_ARB_TIMEOUT_EN
      // Multiplier never answers the first request; the queued one is served normally.
      mul_en = 0;
      ack_log.delete();
      fork
         do_req(0, 16'h0505);
         begin @(posedge clk); #1; do_req(1, 16'h0304); end
         begin
            n = 0;
            while (ack[0] !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
            mul_en = 1;
         end
      join
      check("tmo_count", 32'(ack_log.size()), 2);
      if (ack_log.size() >= 2) begin
         check("tmo_abort_id", 32'(ack_log[0].id), 0);
         check("tmo_abort_err", 32'(ack_log[0].err), 1);
         check("tmo_abort_prod", 32'(ack_log[0].prod), 0);
         check("tmo_next_id", 32'(ack_log[1].id), 1);
         check("tmo_next_err", 32'(ack_log[1].err), 0);
         check("tmo_next_prod", 32'(ack_log[1].prod), 32'h000C);
      end
`endif

      repeat (8) @(posedge clk);
      #1;
      check("grants_outstanding", 32'(exp_grant.size()), 0);
      check("results_outstanding", 32'(exp_done.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
